fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream.sv | 76 +++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain adapter: pulls words from a FIFO with registered rdata and
// presents them as a first-word-fall-through valid/ready stream via a 3-entry skid buffer.
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  output logic                 rinc,
  input  logic                 rempty,
  input  logic [WIDTH-1:0]     rdata,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [1:0]           m_level,
  output logic [CNT_WIDTH-1:0] rd_count
);

  logic [1:0]           occ_q, occ_d;
  logic [1:0]           wptr_q, wptr_d;
  logic [1:0]           rptr_q, rptr_d;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     mem_q [3];
  logic [2:0]           credit;
  logic                 issue;
  logic                 pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts words already buffered plus the one in flight on rdata,
  // so a captured word always finds a free slot without looking at m_ready.
  assign credit  = {1'b0, occ_q} + {2'b00, pend_q};
  assign rinc    = !rrst && !rempty && (credit < 3'd3);
  assign issue   = rinc && !rempty;
  assign pop     = m_valid && m_ready;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = mem_q[rptr_q];
  assign m_level  = occ_q;
  assign rd_count = cnt_q;

  always_comb begin
    pend_d = issue;
    wptr_d = pend_q ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = pop ? cnt_q + 1'b1 : cnt_q;
    occ_d  = occ_q;
    case ({pend_q, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      occ_q  <= occ_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      if (pend_q) mem_q[wptr_q] <= rdata;
    end
  end

endmodule
